// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the M-stage data-memory bus controller.
// Provides the controller state enum, funct3 size/sign codes, the default
// bus timeout and small helpers that classify a funct3 code by access size.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Any code that is neither a byte nor a half access is handled as a word.
  function automatic logic f3_is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Handshaked data-bus bundle between the M-stage controller (master) and the
// data memory / bus fabric (slave).
//   bus_req   master->slave  transaction request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_wdata master->slave  lane-replicated store data
//   bus_be    master->slave  byte enables
//   bus_ack   slave->master  transaction complete this cycle
//   bus_rdata slave->master  read word, valid with bus_ack
//   bus_err   slave->master  transaction failed, valid with bus_ack
interface dmem_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/half lane of a bus read word and
// sign- or zero-extends it to 32 bits according to funct3.
//   rdata_word  in  32  raw word from the bus
//   addr_lo     in  2   byte offset of the access
//   funct3      in  3   access size/sign code
//   data        out 32  extended load result
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    unique case (addr_lo)
      2'd0:    lane_b = rdata_word[7:0];
      2'd1:    lane_b = rdata_word[15:8];
      2'd2:    lane_b = rdata_word[23:16];
      default: lane_b = rdata_word[31:24];
    endcase

    lane_h = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'd0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'd0, lane_h};
      default: data = rdata_word;
    endcase
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// M-stage data-memory controller. Turns a single-cycle load/store request into
// one byte-enabled bus transaction, stalls the pipeline while the bus is busy,
// and returns the extended load data for one cycle in DONE.
//   clk, reset            clock, asynchronous active-low reset
//   mem_read_m/write_m    load / store request (store wins if both)
//   funct3_m              size/sign code
//   alu_result_m          byte address
//   dmem_write_data_m     right-justified store data
//   dmem_read_data_m      extended load result, nonzero only in DONE
//   stall_m               freeze F/D/X/M
//   misaligned_m          current M access is misaligned (combinational)
//   fault_m               one-cycle pulse in DONE on bus error or timeout
//   bus                   master side of the data bus
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read_m,
  input  logic                   mem_write_m,
  input  logic [2:0]             funct3_m,
  input  logic [31:0]            alu_result_m,
  input  logic [31:0]            dmem_write_data_m,
  output logic [31:0]            dmem_read_data_m,
  output logic                   stall_m,
  output logic                   misaligned_m,
  output logic                   fault_m,
  dmem_bus_ctrl_if.master        bus
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  dmem_state_t state_q;
  logic [15:0] cnt_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        start;
  logic        cnt_expired;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_ext;

  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path infers a latch.
    be_n    = 4'b1111;
    wdata_n = dmem_write_data_m;
    is_byte = f3_is_byte(funct3_m);
    is_half = f3_is_half(funct3_m);
    access  = mem_read_m | mem_write_m;
    misaligned = access & ((is_half & alu_result_m[0]) |
                           (~is_byte & ~is_half & (|alu_result_m[1:0])));

    // Loads always fetch the full word; only stores narrow the enables.
    if (mem_write_m) begin
      if (is_byte) begin
        be_n    = 4'b0001 << alu_result_m[1:0];
        wdata_n = {4{dmem_write_data_m[7:0]}};
      end else if (is_half) begin
        be_n    = alu_result_m[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{dmem_write_data_m[15:0]}};
      end
    end
  end

  assign start       = (state_q == IDLE) & access & ~misaligned;
  // The counter holds the number of REQ cycles already spent without an ack.
  assign cnt_expired = (cnt_q + 16'd1) == TIMEOUT_CNT;

  dmem_load_align u_load_align (
    .rdata_word (bus.bus_rdata),
    .addr_lo    (addr_lo_q),
    .funct3     (f3_q),
    .data       (load_ext)
  );

  // Every register, including the latched bus fields, is cleared by reset so the
  // bus presents known values and an abandoned request drops immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      addr_lo_q <= '0;
      f3_q      <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= REQ;
            cnt_q     <= '0;
            req_q     <= 1'b1;
            we_q      <= mem_write_m;
            addr_q    <= {alu_result_m[31:2], 2'b00};
            wdata_q   <= wdata_n;
            be_q      <= be_n;
            addr_lo_q <= alu_result_m[1:0];
            f3_q      <= funct3_m;
          end
        end
        REQ: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (bus.bus_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            fault_q <= bus.bus_err;
            rdata_q <= (we_q | bus.bus_err) ? 32'd0 : load_ext;
          end else if (cnt_expired) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_m          = start | (state_q == REQ);
  assign misaligned_m     = misaligned;
  assign dmem_read_data_m = (state_q == DONE) ? rdata_q : 32'd0;
  assign fault_m          = (state_q == DONE) & fault_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed cases with literal results,
// an asynchronous reset in the middle of a request, then randomized traffic
// compared every cycle against a transaction-level model.
module tb_dmem_bus_ctrl;
  import dmem_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] dmem_write_data_m;
  logic [31:0] dmem_read_data_m;
  logic        stall_m;
  logic        misaligned_m;
  logic        fault_m;

  dmem_bus_ctrl_if bus_if ();

  dmem_bus_ctrl #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_m        (mem_read_m),
    .mem_write_m       (mem_write_m),
    .funct3_m          (funct3_m),
    .alu_result_m      (alu_result_m),
    .dmem_write_data_m (dmem_write_data_m),
    .dmem_read_data_m  (dmem_read_data_m),
    .stall_m           (stall_m),
    .misaligned_m      (misaligned_m),
    .fault_m           (fault_m),
    .bus               (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs, written by the driver only.
  logic        exp_valid;
  int          txn_cyc;
  logic        exp_stall, exp_req, exp_mis, exp_fault;
  logic [31:0] exp_data;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_we, exp_wd_known;
  logic [3:0]  exp_be;

  // Observations of the current transaction, written by the monitor only.
  int          obs_stall;
  int          obs_fault_cyc;
  logic [31:0] obs_done;
  logic        obs_req_seen, obs_mis, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  // ---------------- model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int lo,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * lo);
    case (f3)
      3'd0:    return 32'(int'($signed(sh[7:0])));
      3'd4:    return sh & 32'h0000_00FF;
      3'd1:    return 32'(int'($signed(sh[15:0])));
      3'd5:    return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      if (txn_cyc == 0) begin
        obs_stall = 0; obs_fault_cyc = -1; obs_done = '0;
        obs_req_seen = 1'b0; obs_mis = 1'b0;
      end
      check("stall_m",      {31'd0, stall_m},        {31'd0, exp_stall});
      check("bus_req",      {31'd0, bus_if.bus_req}, {31'd0, exp_req});
      check("misaligned_m", {31'd0, misaligned_m},   {31'd0, exp_mis});
      check("fault_m",      {31'd0, fault_m},        {31'd0, exp_fault});
      check("read_data",    dmem_read_data_m,        exp_data);
      check("bus_addr",     bus_if.bus_addr,         exp_addr);
      check("bus_we",       {31'd0, bus_if.bus_we},  {31'd0, exp_we});
      check("bus_be",       {28'd0, bus_if.bus_be},  {28'd0, exp_be});
      if (exp_wd_known) check("bus_wdata", bus_if.bus_wdata, exp_wdata);
      if (stall_m) obs_stall++;
      if (fault_m) obs_fault_cyc = txn_cyc;
      if (misaligned_m) obs_mis = 1'b1;
      if (bus_if.bus_req) begin
        obs_req_seen = 1'b1; obs_be = bus_if.bus_be;
        obs_we = bus_if.bus_we; obs_wdata = bus_if.bus_wdata;
      end
      if (txn_cyc > 0 && !stall_m) obs_done = dmem_read_data_m;
    end
  end

  // ---------------- driver ----------------
  // One M-stage access: cycle 0 in IDLE, REQ cycles 1..k, DONE at k+1.
  // ack_at is the REQ cycle in which the slave acks; beyond TO means never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata, input logic err);
    int          sz, k;
    logic        is_acc, mis, flt;
    logic [31:0] res, rep;
    is_acc = rd | wr;
    sz     = size_of(f3);
    mis    = is_acc && ((addr % sz) != 0);

    @(posedge clk); #1;
    txn_cyc = 0;
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
    alu_result_m = addr; dmem_write_data_m = wd;
    // Outside REQ the ack lines are noise and must be ignored.
    bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
    bus_if.bus_err = 1'($urandom % 2);
    exp_valid = 1'b1;
    exp_stall = is_acc && !mis; exp_req = 1'b0; exp_mis = mis;
    exp_data = '0; exp_fault = 1'b0;
    if (!is_acc || mis) return;

    if (ack_at <= TO) begin
      k = ack_at; flt = err;
      res = (wr || err) ? 32'd0 : model_load(rdata, int'(addr % 4), f3);
    end else begin
      k = TO; flt = 1'b1; res = 32'd0;
    end
    if (sz == 1)      rep = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (sz == 2) rep = {16'd0, wd[15:0]} * 32'h0001_0001;
    else              rep = wd;

    for (int j = 1; j <= k; j++) begin
      @(posedge clk); #1;
      txn_cyc = j;
      if (j == 1) begin
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_we   = wr;
        exp_be   = wr ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'hF;
        exp_wdata = rep; exp_wd_known = wr;
      end
      bus_if.bus_ack   = (j == ack_at);
      bus_if.bus_rdata = (j == ack_at) ? rdata : $urandom;
      bus_if.bus_err   = (j == ack_at) ? err : 1'($urandom % 2);
      exp_stall = 1'b1; exp_req = 1'b1; exp_mis = 1'b0;
      exp_data = '0; exp_fault = 1'b0;
    end

    @(posedge clk); #1;
    txn_cyc = k + 1;
    bus_if.bus_ack = (ack_at == k + 1) ? 1'b1 : 1'($urandom % 2);
    bus_if.bus_rdata = $urandom; bus_if.bus_err = 1'($urandom % 2);
    exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0;
    exp_data = res; exp_fault = flt;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Abort guard: the run must never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sz;

    reset = 1'b0;
    mem_read_m = 1'b0; mem_write_m = 1'b0; funct3_m = '0;
    alu_result_m = '0; dmem_write_data_m = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;
    exp_valid = 1'b0; txn_cyc = 0;
    exp_addr = '0; exp_we = 1'b0; exp_be = '0; exp_wdata = '0; exp_wd_known = 1'b1;

    // Reset state.
    #12;
    check("rst_bus_req",   {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_bus_we",    {31'd0, bus_if.bus_we},  32'd0);
    check("rst_bus_be",    {28'd0, bus_if.bus_be},  32'd0);
    check("rst_bus_addr",  bus_if.bus_addr,         32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata,        32'd0);
    check("rst_read_data", dmem_read_data_m,        32'd0);
    check("rst_fault",     {31'd0, fault_m},        32'd0);
    @(negedge clk); reset = 1'b1;

    // LW, ack in first REQ cycle.
    run_access(1, 0, F3_W, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 0); settle();
    check("lw_stall_cycles", 32'(obs_stall), 32'd2);
    check("lw_data",         obs_done,       32'hDEAD_BEEF);
    check("lw_be",           {28'd0, obs_be}, 32'h0000_000F);

    // LB / LBU at lane 3.
    run_access(1, 0, F3_B, 32'h103, 32'h0, 1, 32'h8011_2233, 0); settle();
    check("lb_data", obs_done, 32'hFFFF_FF80);
    run_access(1, 0, F3_BU, 32'h103, 32'h0, 1, 32'h8011_2233, 0); settle();
    check("lbu_data", obs_done, 32'h0000_0080);

    // SH at upper half, ack after 3 REQ cycles.
    run_access(0, 1, F3_H, 32'h102, 32'h0000_ABCD, 3, 32'h5555_5555, 0); settle();
    check("sh_be",           {28'd0, obs_be}, 32'h0000_000C);
    check("sh_wdata",        obs_wdata,       32'hABCD_ABCD);
    check("sh_we",           {31'd0, obs_we}, 32'd1);
    check("sh_stall_cycles", 32'(obs_stall),  32'd4);
    check("sh_data",         obs_done,        32'd0);

    // Misaligned LW.
    run_access(1, 0, F3_W, 32'h101, 32'h0, 1, 32'h0, 0); settle();
    check("mis_flag",     {31'd0, obs_mis},      32'd1);
    check("mis_req_seen", {31'd0, obs_req_seen}, 32'd0);
    check("mis_stall",    32'(obs_stall),        32'd0);

    // Timeout with no ack, then ack carrying an error.
    run_access(1, 0, F3_W, 32'h104, 32'h0, 100, 32'h0, 0); settle();
    check("to_fault_cycle", 32'(obs_fault_cyc), 32'd5);
    check("to_data",        obs_done,           32'd0);
    run_access(1, 0, F3_W, 32'h108, 32'h0, 2, 32'h1234_5678, 1); settle();
    check("err_fault_cycle", 32'(obs_fault_cyc), 32'd3);
    check("err_data",        obs_done,           32'd0);

    // Reset in the middle of REQ.
    exp_valid = 1'b0;
    @(posedge clk); #1;
    mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = F3_W; alu_result_m = 32'h200;
    bus_if.bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("mid_req_before_reset", {31'd0, bus_if.bus_req}, 32'd1);
    reset = 1'b0; #1;
    check("mid_req_async_drop", {31'd0, bus_if.bus_req}, 32'd0);
    check("mid_req_addr_clr",   bus_if.bus_addr,         32'd0);
    mem_read_m = 1'b0;
    @(negedge clk);
    check("mid_req_idle_stall", {31'd0, stall_m}, 32'd0);
    reset = 1'b1;
    exp_addr = '0; exp_we = 1'b0; exp_be = '0; exp_wdata = '0; exp_wd_known = 1'b1;
    run_access(1, 0, F3_W, 32'h10C, 32'h0, 2, 32'h1357_9BDF, 0); settle();
    check("post_reset_data",  obs_done,       32'h1357_9BDF);
    check("post_reset_stall", 32'(obs_stall), 32'd3);

    // Randomized traffic with idle gaps and back-to-back accesses.
    for (int t = 0; t < 400; t++) begin
      rd = 1'($urandom % 2);
      wr = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
      sz = size_of(f3);
      addr = $urandom;
      if ($urandom % 4 != 0) addr = addr & ~32'(sz - 1);
      run_access(rd, wr, f3, addr, $urandom, int'($urandom_range(1, TO + 2)),
                 $urandom, ($urandom % 4) == 0);
      for (int g = int'($urandom % 3); g > 0; g--)
        run_access(0, 0, 3'($urandom), $urandom, $urandom, 1, $urandom, 0);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
